// File: rtl/uart_time_rx.sv
// 8N1 UART receiver that reassembles 3-byte {min, seg, cent} time frames.
// Optional feature macro: UART_TIME_RX_RANGE_CHECK_EN (reject out-of-range frames).
module uart_time_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx_pin,
    output logic [3:0] o_min,
    output logic [5:0] o_seg,
    output logic [6:0] o_cent,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_TC       = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W        = $clog2(GAP_TC + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_RELOAD  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] HALF_RELOAD = BIT_CNT_W'(HALF_BIT);
    localparam logic [GAP_W-1:0]     GAP_RELOAD  = GAP_W'(GAP_TC);

    // state   | meaning
    // B_IDLE  | line idle, waiting for a falling edge
    // B_START | timing to mid start bit to confirm it
    // B_DATA  | sampling 8 data bits, LSB first
    // B_STOP  | sampling the stop bit
    // F_MIN / F_SEG / F_CENT | next byte expected is minutes / seconds / hundredths
    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    localparam logic [1:0] F_MIN  = 2'd0;
    localparam logic [1:0] F_SEG  = 2'd1;
    localparam logic [1:0] F_CENT = 2'd2;

    logic                 rx_meta_q, rx_sync_q;
    logic [1:0]           bit_state_q, bit_state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 byte_rdy_q, byte_rdy_d;
    logic                 stop_err_q, stop_err_d;

    logic [1:0]           frame_q, frame_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [3:0]           min_q, min_d;
    logic [5:0]           seg_q, seg_d;
    logic [3:0]           out_min_q, out_min_d;
    logic [5:0]           out_seg_q, out_seg_d;
    logic [6:0]           out_cent_q, out_cent_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_tick;
    logic                 gap_counting;
    logic                 timeout;
    logic                 frame_ok;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
    logic                 bad_q, bad_d;
`endif

    assign bit_tick = (bit_cnt_q == '0);

    always_comb begin
        bit_state_d = bit_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        byte_rdy_d  = 1'b0;
        stop_err_d  = 1'b0;
        case (bit_state_q)
            B_IDLE: begin
                if (!rx_sync_q) begin
                    bit_state_d = B_START;
                    bit_cnt_d   = HALF_RELOAD;
                end
            end
            B_START: begin
                if (bit_tick) begin
                    if (!rx_sync_q) begin
                        bit_state_d = B_DATA;
                        bit_cnt_d   = BIT_RELOAD;
                        bit_idx_d   = 3'd0;
                    end else begin
                        bit_state_d = B_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            B_DATA: begin
                if (bit_tick) begin
                    shreg_d   = {rx_sync_q, shreg_q[7:1]};
                    bit_cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = B_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            B_STOP: begin
                if (bit_tick) begin
                    bit_state_d = B_IDLE;
                    if (rx_sync_q) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        stop_err_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: bit_state_d = B_IDLE;
        endcase
    end

    // shreg_q is stable while byte_rdy_q is high: shifting only happens in B_DATA.
    assign gap_counting = (frame_q != F_MIN) && (bit_state_q == B_IDLE);
    assign timeout      = gap_counting && (gap_q == GAP_W'(1));

`ifdef UART_TIME_RX_RANGE_CHECK_EN
    assign frame_ok = !bad_q && !shreg_q[7] && (shreg_q[6:0] <= 7'd99);
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        frame_d    = frame_q;
        min_d      = min_q;
        seg_d      = seg_q;
        out_min_d  = out_min_q;
        out_seg_d  = out_seg_q;
        out_cent_d = out_cent_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
        bad_d      = bad_q;
`endif
        if (byte_rdy_q || (frame_q == F_MIN)) begin
            gap_d = GAP_RELOAD;
        end else if (gap_counting && (gap_q != '0)) begin
            gap_d = gap_q - 1'b1;
        end else begin
            gap_d = gap_q;
        end

        if (byte_rdy_q) begin
            case (frame_q)
                F_MIN: begin
                    min_d   = shreg_q[3:0];
                    frame_d = F_SEG;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
                    bad_d   = |shreg_q[7:4];
`endif
                end
                F_SEG: begin
                    seg_d   = shreg_q[5:0];
                    frame_d = F_CENT;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
                    bad_d   = bad_q | (|shreg_q[7:6]) | (shreg_q[5:0] > 6'd59);
`endif
                end
                F_CENT: begin
                    frame_d = F_MIN;
                    if (frame_ok) begin
                        out_min_d  = min_q;
                        out_seg_d  = seg_q;
                        out_cent_d = shreg_q[6:0];
                        valid_d    = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: frame_d = F_MIN;
            endcase
        end else if (stop_err_q || timeout) begin
            ferr_d  = 1'b1;
            frame_d = F_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            bit_state_q <= B_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'd0;
            byte_rdy_q  <= 1'b0;
            stop_err_q  <= 1'b0;
            frame_q     <= F_MIN;
            gap_q       <= GAP_RELOAD;
            min_q       <= 4'd0;
            seg_q       <= 6'd0;
            out_min_q   <= 4'd0;
            out_seg_q   <= 6'd0;
            out_cent_q  <= 7'd0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
            bad_q       <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= i_rx_pin;
            rx_sync_q   <= rx_meta_q;
            bit_state_q <= bit_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            byte_rdy_q  <= byte_rdy_d;
            stop_err_q  <= stop_err_d;
            frame_q     <= frame_d;
            gap_q       <= gap_d;
            min_q       <= min_d;
            seg_q       <= seg_d;
            out_min_q   <= out_min_d;
            out_seg_q   <= out_seg_d;
            out_cent_q  <= out_cent_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
`ifdef UART_TIME_RX_RANGE_CHECK_EN
            bad_q       <= bad_d;
`endif
        end
    end

    assign o_min       = out_min_q;
    assign o_seg       = out_seg_q;
    assign o_cent      = out_cent_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (bit_state_q != B_IDLE) || (frame_q != F_MIN);

endmodule

// File: tb/tb_uart_time_rx.sv
// Directed bench for uart_time_rx: table of whole frames plus hand-written
// sequences for false start, stop-bit error, gap timeout and mid-frame reset.
module tb_uart_time_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] o_min;
    logic [5:0] o_seg;
    logic [6:0] o_cent;
    logic       o_valid, o_frame_err, o_busy;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both_cnt = 0;
    int busy_seen = 0;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         exp_v, exp_e;
        int         min, seg, cent;
    } vec_t;

    vec_t vecs[5];

    uart_time_rx #(
        .CLK_FREQ(1000000),
        .BAUD(62500),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_rx_pin(rx),
        .o_min(o_min),
        .o_seg(o_seg),
        .o_cent(o_cent),
        .o_valid(o_valid),
        .o_frame_err(o_frame_err),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (o_valid) vcnt++;
        if (o_frame_err) ecnt++;
        if (o_valid && o_frame_err) both_cnt++;
        if (o_busy) busy_seen++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (12) @(negedge clk);
            rx = 1'b1;
            repeat (CPB - 12) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        idle(CPB);
    endtask

    task automatic check_outs(input string tag, input int m, input int s, input int c);
        check({tag, " min"}, int'(o_min), m);
        check({tag, " seg"}, int'(o_seg), s);
        check({tag, " cent"}, int'(o_cent), c);
    endtask

    initial begin
        int v0, e0, b0;
        int pm, ps, pc;

        vecs[0] = '{8'h03, 8'h2A, 8'h3F, 1, 0, 3, 42, 63};
        vecs[1] = '{8'h00, 8'h3B, 8'h63, 1, 0, 0, 59, 99};
`ifdef UART_TIME_RX_RANGE_CHECK_EN
        vecs[2] = '{8'h01, 8'h3C, 8'h10, 0, 1, 0, 59, 99};
        vecs[3] = '{8'h0F, 8'h00, 8'h00, 1, 0, 15, 0, 0};
        vecs[4] = '{8'hF9, 8'hC5, 8'hE4, 0, 1, 15, 0, 0};
`else
        vecs[2] = '{8'h01, 8'h3C, 8'h10, 1, 0, 1, 60, 16};
        vecs[3] = '{8'h0F, 8'h00, 8'h00, 1, 0, 15, 0, 0};
        vecs[4] = '{8'hF9, 8'hC5, 8'hE4, 1, 0, 9, 5, 100};
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0);
        check("reset valid", int'(o_valid), 0);
        check("reset ferr", int'(o_frame_err), 0);
        check("reset busy", int'(o_busy), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(4);

        // table of whole frames
        for (int i = 0; i < 5; i++) begin
            v0 = vcnt;
            e0 = ecnt;
            send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
            check($sformatf("vec%0d valid", i), vcnt - v0, vecs[i].exp_v);
            check($sformatf("vec%0d ferr", i), ecnt - e0, vecs[i].exp_e);
            check_outs($sformatf("vec%0d", i), vecs[i].min, vecs[i].seg, vecs[i].cent);
            check($sformatf("vec%0d busy", i), int'(o_busy), 0);
        end
        pm = vecs[4].min;
        ps = vecs[4].seg;
        pc = vecs[4].cent;

        // short low glitch: false start, no byte, no error
        v0 = vcnt;
        e0 = ecnt;
        b0 = busy_seen;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        check("glitch busy seen", int'((busy_seen - b0) > 0), 1);
        check("glitch busy after", int'(o_busy), 0);
        check("glitch valid", vcnt - v0, 0);
        check("glitch ferr", ecnt - e0, 0);

        // stop-bit error on second byte drops the partial frame
        v0 = vcnt;
        e0 = ecnt;
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b0);
        idle(3 * CPB);
        check("stoperr ferr", ecnt - e0, 1);
        check("stoperr valid", vcnt - v0, 0);
        check_outs("stoperr hold", pm, ps, pc);
        check("stoperr busy", int'(o_busy), 0);
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h01, 8'h02, 8'h03);
        check("after stoperr valid", vcnt - v0, 1);
        check("after stoperr ferr", ecnt - e0, 0);
        check_outs("after stoperr", 1, 2, 3);

        // idle gap inside a frame triggers the timeout
        v0 = vcnt;
        e0 = ecnt;
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        idle(19 * CPB);
        check("timeout early", ecnt - e0, 0);
        check("timeout busy pending", int'(o_busy), 1);
        idle(2 * CPB);
        check("timeout ferr", ecnt - e0, 1);
        check("timeout valid", vcnt - v0, 0);
        check("timeout busy", int'(o_busy), 0);
        check_outs("timeout hold", 1, 2, 3);
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h00, 8'h3B, 8'h63);
        check("after timeout valid", vcnt - v0, 1);
        check("after timeout ferr", ecnt - e0, 0);
        check_outs("after timeout", 0, 59, 99);

        // reset in the middle of the second byte
        v0 = vcnt;
        e0 = ecnt;
        send_byte(8'h04, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("midreset", 0, 0, 0);
        check("midreset busy", int'(o_busy), 0);
        check("midreset valid", int'(o_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2 * CPB);
        send_frame(8'h06, 8'h07, 8'h08);
        check("after reset valid", vcnt - v0, 1);
        check("after reset ferr", ecnt - e0, 0);
        check_outs("after reset", 6, 7, 8);

        check("valid and ferr together", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
